// File: rtl/alu_mc_pkg.sv
// alu_mc_pkg: operation codes and FSM states shared by alu_mc and its iterative MUL/DIV unit.
package alu_mc_pkg;
    localparam logic [3:0] F_ADD  = 4'd0;
    localparam logic [3:0] F_SUB  = 4'd1;
    localparam logic [3:0] F_AND  = 4'd2;
    localparam logic [3:0] F_OR   = 4'd3;
    localparam logic [3:0] F_XOR  = 4'd4;
    localparam logic [3:0] F_LSL  = 4'd5;
    localparam logic [3:0] F_LSR  = 4'd6;
    localparam logic [3:0] F_NOT  = 4'd7;
    localparam logic [3:0] F_DIV  = 4'd8;
    localparam logic [3:0] F_MUL  = 4'd9;
    localparam logic [3:0] F_ROL  = 4'd10;
    localparam logic [3:0] F_ROR  = 4'd11;
    localparam logic [3:0] F_ASR  = 4'd12;
    localparam logic [3:0] F_BREV = 4'd13;
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
endpackage

// File: rtl/alu_mc_iter.sv
// alu_mc_iter: shift-add multiplier / restoring divider, WIDTH steps with the first step taken on start.
// hi_nonzero reports upper product bits for MUL and divide-by-zero for DIV.
module alu_mc_iter import alu_mc_pkg::*; #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             hi_nonzero
);
    localparam int CW = $clog2(WIDTH);
    logic [CW-1:0]    r_cnt;
    logic             r_div;
    logic [WIDTH-1:0] r_hi, r_lo, r_d;
    logic             w_div, w_ge;
    logic [WIDTH-1:0] w_hi, w_lo, w_d, w_diff;
    logic [WIDTH:0]   w_sum, w_trial;
    // On start the step operates on fresh operands so WIDTH steps fit in WIDTH cycles
    assign w_div   = start ? (op == F_DIV) : r_div;
    assign w_hi    = start ? '0 : r_hi;
    assign w_lo    = start ? b : r_lo;
    assign w_d     = start ? a : r_d;
    assign w_sum   = {1'b0, w_hi} + (w_lo[0] ? {1'b0, w_d} : '0);
    assign w_trial = {w_hi, w_lo[WIDTH-1]};
    assign w_ge    = w_trial >= {1'b0, w_d};
    assign w_diff  = w_trial[WIDTH-1:0] - w_d;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_div <= 1'b0;
            r_hi  <= '0;
            r_lo  <= '0;
            r_d   <= '0;
        end else if (start || r_cnt != '0) begin
            r_cnt <= start ? CW'(WIDTH - 1) : r_cnt - CW'(1);
            r_div <= w_div;
            r_d   <= w_d;
            r_hi  <= w_div ? (w_ge ? w_diff : w_trial[WIDTH-1:0]) : w_sum[WIDTH:1];
            r_lo  <= w_div ? {w_lo[WIDTH-2:0], w_ge} : {w_sum[0], w_lo[WIDTH-1:1]};
        end
    end
    assign done       = r_cnt == '0;
    assign result     = r_lo;
    assign hi_nonzero = r_div ? (r_d == '0) : |r_hi;
endmodule

// File: rtl/alu_mc.sv
// alu_mc: ALU with valid/ready handshake and registered result/flags.
// ALU_MC_ITER_EN selects the iterative MUL/DIV unit; otherwise MUL/DIV finish in one cycle.
module alu_mc import alu_mc_pkg::*; #(
    parameter int WIDTH = 16,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       alu_func,
    input  logic [WIDTH-1:0] alu_a,
    input  logic [WIDTH-1:0] alu_b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] alu_out,
    output logic             c,
    output logic             z,
    output logic             v,
    output logic             s,
    output logic             busy
);
    localparam int M = WIDTH - 1;
    state_t           r_state;
    logic [WIDTH-1:0] r_out;
    logic             r_c, r_z, r_v, r_s;
    logic [SHW-1:0]   w_sh;
    logic [WIDTH:0]   w_add, w_sub, w_lsl, w_lsr;
    logic [WIDTH-1:0] w_res, w_rol, w_ror, w_asr, w_brev, w_ires;
    logic             w_c, w_v, w_go_busy, w_done, w_hi_nz;
    assign w_sh   = alu_a[SHW-1:0];
    assign w_add  = {1'b0, alu_b} + {1'b0, alu_a} + {{WIDTH{1'b0}}, cin};
    assign w_sub  = {1'b0, alu_b} - {1'b0, alu_a} - {{WIDTH{1'b0}}, cin};
    assign w_lsl  = {1'b0, alu_b} << w_sh;
    assign w_lsr  = {alu_b, 1'b0} >> w_sh;
    assign w_rol  = (alu_b << w_sh) | (alu_b >> (WIDTH - int'(w_sh)));
    assign w_ror  = (alu_b >> w_sh) | (alu_b << (WIDTH - int'(w_sh)));
    assign w_asr  = $signed(alu_b) >>> w_sh;
    assign w_brev = {<<{alu_b}};
`ifdef ALU_MC_ITER_EN
    assign w_go_busy = alu_func == F_MUL || alu_func == F_DIV;
    alu_mc_iter #(.WIDTH(WIDTH)) u_iter (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (r_state == IDLE && in_valid && w_go_busy),
        .op         (alu_func),
        .a          (alu_a),
        .b          (alu_b),
        .done       (w_done),
        .result     (w_ires),
        .hi_nonzero (w_hi_nz)
    );
`else
    logic [2*WIDTH-1:0] w_prod;
    assign w_prod    = {{WIDTH{1'b0}}, alu_b} * {{WIDTH{1'b0}}, alu_a};
    assign w_go_busy = 1'b0;
    assign w_done    = 1'b0;
    assign w_ires    = '0;
    assign w_hi_nz   = 1'b0;
`endif
    always_comb begin
        w_res = '0;
        w_c   = 1'b0;
        w_v   = 1'b0;
        case (alu_func)
            F_ADD: begin
                {w_c, w_res} = w_add;
                w_v = (alu_a[M] == alu_b[M]) && (w_add[M] != alu_b[M]);
            end
            F_SUB: begin
                {w_c, w_res} = w_sub;
                w_v = (alu_a[M] != alu_b[M]) && (w_sub[M] != alu_b[M]);
            end
            F_AND:  w_res = alu_a & alu_b;
            F_OR:   w_res = alu_a | alu_b;
            F_XOR:  w_res = alu_a ^ alu_b;
            F_LSL:  {w_c, w_res} = w_lsl;
            F_LSR:  {w_res, w_c} = w_lsr;
            F_NOT:  w_res = ~alu_b;
`ifndef ALU_MC_ITER_EN
            F_DIV: begin
                w_res = (alu_a == '0) ? '1 : alu_b / alu_a;
                w_v   = alu_a == '0;
            end
            F_MUL: begin
                w_res = w_prod[WIDTH-1:0];
                w_v   = |w_prod[2*WIDTH-1:WIDTH];
            end
`endif
            F_ROL:  w_res = w_rol;
            F_ROR:  w_res = w_ror;
            F_ASR:  w_res = w_asr;
            F_BREV: w_res = w_brev;
            default: ;
        endcase
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_out   <= '0;
            r_c     <= 1'b0;
            r_z     <= 1'b0;
            r_v     <= 1'b0;
            r_s     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (in_valid) begin
                    r_state <= w_go_busy ? BUSY : DONE;
                    r_out   <= w_res;
                    r_c     <= w_c;
                    r_v     <= w_v;
                    r_z     <= w_res == '0;
                    r_s     <= w_res[M];
                end
                BUSY: if (w_done) begin
                    r_state <= DONE;
                    r_out   <= w_ires;
                    r_c     <= 1'b0;
                    r_v     <= w_hi_nz;
                    r_z     <= w_ires == '0;
                    r_s     <= w_ires[M];
                end
                default: if (out_ready) r_state <= IDLE;
            endcase
        end
    end
    assign in_ready  = r_state == IDLE;
    assign out_valid = r_state == DONE;
    assign busy      = r_state == BUSY;
    assign alu_out   = r_out;
    assign c         = r_c;
    assign z         = r_z;
    assign v         = r_v;
    assign s         = r_s;
endmodule

// File: tb/tb_alu_mc.sv
// tb_alu_mc: table-driven scoreboard bench for alu_mc, plus hold and mid-operation reset sequences.
module tb_alu_mc;
    import alu_mc_pkg::*;
    localparam int W = 16;
`ifdef ALU_MC_ITER_EN
    localparam int LAT   = W + 1;
    localparam int BUSYC = W;
`else
    localparam int LAT   = 1;
    localparam int BUSYC = 0;
`endif
    logic         clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, cin = 1'b0, out_ready = 1'b0;
    logic [3:0]   alu_func = '0;
    logic [W-1:0] alu_a = '0, alu_b = '0;
    logic         in_ready, out_valid, c, z, v, s, busy;
    logic [W-1:0] alu_out;
    typedef struct {
        logic [3:0]   f;
        logic [W-1:0] a, b;
        logic         ci;
        logic [W-1:0] r;
        logic [3:0]   czvs;
    } vec_t;
    typedef struct {
        logic [W-1:0] r;
        logic [3:0]   czvs;
    } exp_t;
    vec_t vt[26];
    exp_t sbq[$];
    int   checks = 0, errors = 0;
    alu_mc #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .alu_func(alu_func), .alu_a(alu_a), .alu_b(alu_b), .cin(cin),
        .out_valid(out_valid), .out_ready(out_ready), .alu_out(alu_out),
        .c(c), .z(z), .v(v), .s(s), .busy(busy)
    );
    always #5 clk = ~clk;
    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end
    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask
    function automatic vec_t mk(input logic [3:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                                input logic ci, input logic [W-1:0] r, input logic [3:0] czvs);
        vec_t t;
        t.f = f; t.a = a; t.b = b; t.ci = ci; t.r = r; t.czvs = czvs;
        return t;
    endfunction
    task automatic run_op(input vec_t t, input int hold, input string nm);
        int   n, lat, bc;
        exp_t e;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            check({nm, " in_ready wait"}, in_ready, 1);
            return;
        end
        alu_func = t.f; alu_a = t.a; alu_b = t.b; cin = t.ci; in_valid = 1'b1;
        sbq.push_back('{r: t.r, czvs: t.czvs});
        @(posedge clk);
        @(negedge clk);
        in_valid = (hold > 0);
        lat = 1;
        bc  = 0;
        while (!out_valid && lat < 100) begin
            if (busy) bc++;
            @(negedge clk);
            lat++;
        end
        check({nm, " latency"}, lat, LAT);
        check({nm, " busy cycles"}, bc, BUSYC);
        if (!out_valid || sbq.size() == 0) return;
        e = sbq.pop_front();
        check({nm, " out"}, alu_out, e.r);
        check({nm, " czvs"}, {c, z, v, s}, e.czvs);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check({nm, " held out"}, alu_out, e.r);
            check({nm, " held in_ready"}, {in_ready, out_valid}, 2'b01);
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b0;
        check({nm, " after handshake"}, {in_ready, out_valid}, 2'b10);
    endtask
    initial begin
        int seen;
        vt[0]  = mk(F_ADD,  16'h7FFF, 16'h0001, 1'b0, 16'h8000, 4'b0011);
        vt[1]  = mk(F_SUB,  16'h0001, 16'h0000, 1'b0, 16'hFFFF, 4'b1001);
        vt[2]  = mk(F_ADD,  16'hFFFF, 16'h0001, 1'b0, 16'h0000, 4'b1100);
        vt[3]  = mk(F_ADD,  16'h0001, 16'h0002, 1'b1, 16'h0004, 4'b0000);
        vt[4]  = mk(F_SUB,  16'h0001, 16'h8000, 1'b0, 16'h7FFF, 4'b0010);
        vt[5]  = mk(F_SUB,  16'h0005, 16'h0005, 1'b1, 16'hFFFF, 4'b1001);
        vt[6]  = mk(F_AND,  16'hF0F0, 16'hFF00, 1'b1, 16'hF000, 4'b0001);
        vt[7]  = mk(F_OR,   16'h00F0, 16'h0F00, 1'b0, 16'h0FF0, 4'b0000);
        vt[8]  = mk(F_XOR,  16'hAAAA, 16'hAAAA, 1'b0, 16'h0000, 4'b0100);
        vt[9]  = mk(F_LSL,  16'h0004, 16'h9234, 1'b0, 16'h2340, 4'b1000);
        vt[10] = mk(F_LSL,  16'h0010, 16'h8001, 1'b0, 16'h8001, 4'b0001);
        vt[11] = mk(F_LSR,  16'h0003, 16'h0005, 1'b0, 16'h0000, 4'b1100);
        vt[12] = mk(F_LSR,  16'h0000, 16'h8001, 1'b0, 16'h8001, 4'b0001);
        vt[13] = mk(F_NOT,  16'h0000, 16'h00FF, 1'b0, 16'hFF00, 4'b0001);
        vt[14] = mk(F_ROL,  16'h0004, 16'h1234, 1'b0, 16'h2341, 4'b0000);
        vt[15] = mk(F_ROL,  16'h0000, 16'h8001, 1'b0, 16'h8001, 4'b0001);
        vt[16] = mk(F_ROR,  16'h0004, 16'h1234, 1'b0, 16'h4123, 4'b0000);
        vt[17] = mk(F_ASR,  16'h0004, 16'h8000, 1'b0, 16'hF800, 4'b0001);
        vt[18] = mk(F_BREV, 16'h0000, 16'h0001, 1'b0, 16'h8000, 4'b0001);
        vt[19] = mk(4'd14,  16'h1234, 16'h5678, 1'b0, 16'h0000, 4'b0100);
        vt[20] = mk(4'd15,  16'hFFFF, 16'hFFFF, 1'b1, 16'h0000, 4'b0100);
        vt[21] = mk(F_DIV,  16'h0007, 16'h0064, 1'b0, 16'h000E, 4'b0000);
        vt[22] = mk(F_DIV,  16'h0000, 16'h1234, 1'b0, 16'hFFFF, 4'b0011);
        vt[23] = mk(F_MUL,  16'h0100, 16'h0100, 1'b0, 16'h0000, 4'b0110);
        vt[24] = mk(F_MUL,  16'h0003, 16'h0005, 1'b0, 16'h000F, 4'b0000);
        vt[25] = mk(F_MUL,  16'hFFFF, 16'hFFFF, 1'b0, 16'h0001, 4'b0010);
        repeat (3) @(negedge clk);
        check("reset state", {out_valid, busy, c, z, v, s}, 6'b0);
        check("reset alu_out", alu_out, 16'h0000);
        rst_n = 1'b1;
        @(negedge clk);
        check("ready after reset", {in_ready, out_valid, busy}, 3'b100);
        for (int i = 0; i < 26; i++) run_op(vt[i], 0, $sformatf("vec%0d", i));
        run_op(vt[16], 5, "ror hold");
        // Abandon a MUL mid-flight: no result may appear afterwards
        alu_func = F_MUL; alu_a = 16'h0100; alu_b = 16'h0100; cin = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
`ifdef ALU_MC_ITER_EN
        check("busy before reset", busy, 1);
`endif
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("mid-op reset", {out_valid, busy}, 2'b00);
        rst_n = 1'b1;
        @(negedge clk);
        check("ready after mid-op reset", in_ready, 1);
        seen = 0;
        repeat (25) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("no result after reset", seen, 0);
        run_op(vt[0], 0, "post-reset add");
        check("scoreboard drained", sbq.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
